// File: rtl/sha256_chain_state.sv
// sha256_chain_state: SHA-256 chaining-value bank with block counter and digest handshake.
// Define SHA_CHAIN_DOUBLE_HASH_EN to enable the two-pass (double hash) mode.
module sha256_chain_state #(
  parameter int WORD_W = 32,
  parameter int NUM_WORDS = 8,
  parameter logic [WORD_W*NUM_WORDS-1:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                               32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667},
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init,
  input  logic                        dbl,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic                        upd_last,
  input  logic [WORD_W*NUM_WORDS-1:0] upd_work,
  output logic [WORD_W*NUM_WORDS-1:0] h_state,
  output logic [CNT_W-1:0]            blk_cnt,
  output logic                        cnt_ovf,
  output logic                        pass,
  output logic                        dig_valid,
  input  logic                        dig_ready,
  output logic [WORD_W*NUM_WORDS-1:0] digest
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state;
  logic [WORD_W*NUM_WORDS-1:0] sum;
  logic dbl_go;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      sum[i*WORD_W +: WORD_W] = h_state[i*WORD_W +: WORD_W] + upd_work[i*WORD_W +: WORD_W];
  end
`ifdef SHA_CHAIN_DOUBLE_HASH_EN
  logic dbl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dbl_q <= 1'b0;
    else if (init) dbl_q <= dbl;
  assign dbl_go = dbl_q && !pass;
`else
  logic unused_dbl;
  assign unused_dbl = dbl;
  assign dbl_go = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h_state <= IV;
      digest <= '0;
      blk_cnt <= '0;
      cnt_ovf <= 1'b0;
      pass <= 1'b0;
      dig_valid <= 1'b0;
      upd_ready <= 1'b0;
    end else if (init) begin
      state <= ACCUM;
      h_state <= IV;
      blk_cnt <= '0;
      cnt_ovf <= 1'b0;
      pass <= 1'b0;
      dig_valid <= 1'b0;
      upd_ready <= 1'b1;
    end else begin
      case (state)
        ACCUM: if (upd_valid && upd_ready) begin
          h_state <= sum;
          blk_cnt <= blk_cnt == '1 ? blk_cnt : blk_cnt + 1'b1;
          cnt_ovf <= cnt_ovf | (blk_cnt == '1);
          if (upd_last) begin
            digest <= sum;
            // First pass of a double hash restarts from IV instead of finishing
            if (dbl_go) begin
              h_state <= IV;
              blk_cnt <= '0;
              pass <= 1'b1;
            end else begin
              dig_valid <= 1'b1;
              upd_ready <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE: if (dig_ready) begin
          dig_valid <= 1'b0;
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sha256_chain_state.md
Name: sha256_chain_state

Overview:
- Parametrised chaining-value register bank for the hash core; holds all NUM_WORDS H words rather than one word per module.
- Loads the IV on message start.
- Adds the compressor's working variables into H after each block.
- Counts blocks and presents the final digest through a valid/ready handshake.
- Sits between the message scheduler/compressor and the nonce/result logic.

Parameters:
- WORD_W, 32, width of one H word.
- NUM_WORDS, 8, number of H words.
- IV, SHA-256 IV {5be0cd19,...,6a09e667} (word 0 = 6a09e667 in LSBs), flattened initial value, WORD_W*NUM_WORDS bits.
- CNT_W, 8, width of the block counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init  in  1  single-cycle pulse: start new message (load IV, clear counter).
- dbl  in  1  double-hash request, sampled with init (see Optional Feature).
- upd_valid  in  1  compressor result valid.
- upd_ready  out  1  block accepts an update.
- upd_last  in  1  qualifies upd_valid: final block of the current pass.
- upd_work  in  WORD_W*NUM_WORDS  working variables a..h; word i at bits [i*WORD_W +: WORD_W].
- h_state  out  WORD_W*NUM_WORDS  current chaining value fed to the compressor.
- blk_cnt  out  CNT_W  blocks accumulated in the current pass.
- cnt_ovf  out  1  sticky: a block was accepted with blk_cnt at its maximum.
- pass  out  1  0 = first pass, 1 = second pass.
- dig_valid  out  1  digest available.
- dig_ready  in  1  consumer takes the digest.
- digest  out  WORD_W*NUM_WORDS  final digest.

Behaviour:
- Reset (async, rst_n low):
  - h_state = IV, digest = 0.
  - blk_cnt = 0, cnt_ovf = 0, pass = 0.
  - dig_valid = 0, upd_ready = 0.
  - FSM = IDLE.
- FSM states: IDLE, ACCUM, DONE.
- upd_ready = 1 only in ACCUM. An update is accepted on a clock edge where upd_valid && upd_ready.
- IDLE: init moves to ACCUM and loads h_state = IV. Updates are ignored.
- ACCUM, accepted update:
  - Each word is updated as h[i] <= h[i] + work[i], modulo 2^WORD_W; carries are discarded per word.
  - Updated h_state is visible the cycle after acceptance (1-cycle latency).
  - blk_cnt increments. If blk_cnt is at its maximum it holds at max and cnt_ovf sets.
- ACCUM, accepted update with upd_last = 1 (single pass):
  - digest is loaded with the updated sum in the same edge.
  - dig_valid goes to 1 on the next cycle and FSM moves to DONE.
- DONE:
  - dig_valid is held; digest and h_state are stable.
  - dig_ready = 1 takes the digest: next cycle dig_valid = 0 and FSM = IDLE.
  - h_state keeps the final value until the next init.
- init in any state (abort/restart) wins over a simultaneous update or digest handshake; the same-edge update is dropped:
  - h_state = IV, blk_cnt = 0, cnt_ovf = 0, pass = 0.
  - dig_valid = 0, FSM = ACCUM.
- dig_ready while dig_valid = 0 has no effect.
- Reset mid-message returns to the reset values immediately; there is no partial state.

Optional Feature:
- Macro: SHA_CHAIN_DOUBLE_HASH_EN.
- With the macro defined, dbl is latched at init:
  - If latched dbl = 1, an accepted last update in pass 0 does not complete the message.
  - Instead, digest is loaded with the pass-0 result (for the scheduler to read as the pass-1 message), h_state reloads IV, blk_cnt clears, pass becomes 1, FSM stays ACCUM, and dig_valid stays 0.
  - The last update in pass 1 completes the message normally.
- Without the macro: dbl is ignored, pass is tied 0, and every last update completes the message.

Test Plan:
- Reset -> h_state = IV (word0 0x6a09e667), dig_valid = 0, upd_ready = 0, blk_cnt = 0.
- init; one update with all words 0xFFFFFFFF and upd_last = 1 -> word0 = 0x6a09e666 one cycle later, dig_valid = 1 and digest word0 = 0x6a09e666; hold dig_ready = 0 for 5 cycles -> values stable; dig_ready = 1 -> IDLE.
- init; three updates with all words 0x00000001, the last with upd_last = 1 -> word0 = 0x6a09e66a, blk_cnt = 3; a fourth upd_valid in DONE is not accepted.
- CNT_W = 2, 4 non-last updates -> blk_cnt saturates at 3, cnt_ovf = 1; init clears both.
- init asserted on the same edge as an accepted update -> update dropped, h_state = IV, blk_cnt = 0.
- With SHA_CHAIN_DOUBLE_HASH_EN, dbl = 1: pass-0 last update with all words 0x1 -> digest word0 = 0x6a09e668, h_state = IV, pass = 1, dig_valid = 0; pass-1 last update with all words 0x2 -> dig_valid = 1, digest word0 = 0x6a09e669.
